sample_pacer: RTL and testbench

Elastic sample buffer with a programmable output rate. It sits between the decoder and the modulator. Bursty samples from the decoder (new_sample/sample) are absorbed into a small FIFO. They are released to the modulator as single-cycle new_sample strobes, exactly one every clks_per_sample clocks. This decouples USB/FT245 burst timing from the constant PWM sample rate.

---
 rtl/sample_pacer.sv | 114 +++++++++++
 tb/tb_sample_pacer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_pacer.sv
// Elastic sample FIFO that releases buffered samples as single-cycle strobes,
// one every clks_per_sample clocks, decoupling bursty input from a fixed output rate.
module sample_pacer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    input  logic [DIV_W-1:0]  clks_per_sample,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_new_sample,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DIV_W-1:0]  count;
    logic [DIV_W-1:0]  last_count;
    logic [ADDR_W:0]   level_next;
    logic              tick;
    logic              pop;
    logic              push;
    logic              drop;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        // A divisor of 0 behaves like 1: tick every clock.
        last_count = (clks_per_sample == '0) ? '0 : clks_per_sample - DIV_W'(1);
        // >= lets a mid-period shrink of the divisor fire on the next clock.
        tick       = enable && (count >= last_count);
        pop        = tick && !empty;
        push       = in_valid && (!full || pop);
        drop       = in_valid && full && !pop;
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and level define
    // which entries are meaningful, so resetting the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            level          <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            out_sample     <= '0;
            out_new_sample <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            if (!enable || tick) begin
                count <= '0;
            end else begin
                count <= count + DIV_W'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // A read of mem here sees the pre-write contents, so a full FIFO
            // can pop and accept a write on the same slot in one cycle.
            out_new_sample <= pop;
            if (pop) begin
                out_sample <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end

            level <= level_next;
            full  <= (level_next == FULL_LEVEL);
            empty <= (level_next == '0);

            // Set has priority over clear so no error event is lost.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end

            if (tick && empty) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_pacer.sv
// Directed bench for sample_pacer: stimulus pushes expected strobes into a
// scoreboard queue, a negedge monitor pops and compares data and spacing.
module tb_sample_pacer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  in_sample;
    logic        in_valid;
    logic [15:0] clks_per_sample;
    logic        clr_flags;
    logic [7:0]  out_sample;
    logic        out_new_sample;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        underflow;

    sample_pacer #(.DATA_W(8), .ADDR_W(4), .DIV_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .in_sample       (in_sample),
        .in_valid        (in_valid),
        .clks_per_sample (clks_per_sample),
        .clr_flags       (clr_flags),
        .out_sample      (out_sample),
        .out_new_sample  (out_new_sample),
        .level           (level),
        .full            (full),
        .empty           (empty),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         gap;   // required clocks since previous strobe; 0 = not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   maxlvl = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (int'(level) > maxlvl) maxlvl = int'(level);
        if (out_new_sample === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", {24'd0, out_sample}, {24'd0, mon_e.data});
                if (mon_e.gap != 0) check("out_gap", cyc - last_cyc, mon_e.gap);
            end
            last_cyc = cyc;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input logic [7:0] d, input int gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic write(input logic [7:0] d);
        in_valid  = 1'b1;
        in_sample = d;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            step();
            i++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic idle_clear();
        enable    = 1'b0;
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; in_sample = '0; in_valid = 1'b0;
        clks_per_sample = 16'd4; clr_flags = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_out", out_sample, 0);
        check("rst_strobe", out_new_sample, 0);
        check("rst_flags", {overflow, underflow}, 0);

        // 1: three back-to-back writes at cps=4
        enable = 1'b1;
        expect_out(8'h11, 0); expect_out(8'h22, 4); expect_out(8'h33, 4);
        write(8'h11); write(8'h22); write(8'h33);
        check("t1_level3", level, 3);
        drain("t1_drained", 40);
        check("t1_level0", level, 0);
        check("t1_flags", {overflow, underflow}, 0);
        idle_clear();

        // 2: overfill while paused, then drain at full rate
        for (int i = 0; i < 17; i++) write(8'(i));
        check("t2_level", level, 16);
        check("t2_full", full, 1);
        check("t2_overflow", overflow, 1);
        expect_out(8'h00, 0);
        for (int i = 1; i < 16; i++) expect_out(8'(i), 1);
        clks_per_sample = 16'd1;
        enable = 1'b1;
        drain("t2_drained", 40);
        step();
        check("t2_underflow", underflow, 1);
        check("t2_hold", out_sample, 8'h0F);
        check("t2_empty", empty, 1);
        idle_clear();
        check("t2_cleared", {overflow, underflow}, 0);

        // 3: write on a tick cycle while full is accepted
        for (int i = 0; i < 16; i++) write(8'h40 + 8'(i));
        check("t3_full", full, 1);
        expect_out(8'h40, 0);
        for (int i = 1; i < 16; i++) expect_out(8'h40 + 8'(i), 2);
        expect_out(8'hAA, 2);
        clks_per_sample = 16'd2;
        enable = 1'b1;
        step();
        write(8'hAA);
        check("t3_level", level, 16);
        check("t3_no_overflow", overflow, 0);
        drain("t3_drained", 80);
        idle_clear();

        // 4a/4b: cps=0 and cps=1 both strobe every clock
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) write(8'h50 + 8'(pass * 8 + i));
            for (int i = 0; i < 5; i++) expect_out(8'h50 + 8'(pass * 8 + i), (i == 0) ? 0 : 1);
            clks_per_sample = 16'(pass);
            enable = 1'b1;
            drain("t4_every_clock", 20);
            idle_clear();
        end

        // 4c: divisor drops 100 -> 3 at count 50
        for (int i = 0; i < 4; i++) write(8'h60 + 8'(i));
        for (int i = 0; i < 4; i++) expect_out(8'h60 + 8'(i), (i == 0) ? 0 : 3);
        clks_per_sample = 16'd100;
        enable = 1'b1;
        step(50);
        check("t4_no_early", out_new_sample, 0);
        clks_per_sample = 16'd3;
        step();
        check("t4_next_tick", out_new_sample, 1);
        check("t4_next_data", out_sample, 8'h60);
        drain("t4_drained", 20);
        idle_clear();

        // 5: streaming across pointer wrap
        for (int i = 0; i < 40; i++) expect_out(8'h80 + 8'(i), (i == 0) ? 0 : 3);
        maxlvl = 0;
        clks_per_sample = 16'd3;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            write(8'h80 + 8'(i));
            step(2);
        end
        drain("t5_drained", 20);
        check("t5_max_level", (maxlvl <= 2) ? 32'd1 : 32'd0, 1);
        idle_clear();

        // 6: reset mid-operation with 7 buffered samples
        for (int i = 0; i < 7; i++) write(8'hC0 + 8'(i));
        check("t6_level7", level, 7);
        clks_per_sample = 16'd100;
        enable = 1'b1;
        step(10);
        rst = 1'b1;
        clks_per_sample = 16'd1;
        step();
        rst = 1'b0;
        check("t6_level", level, 0);
        check("t6_empty", empty, 1);
        check("t6_out", out_sample, 0);
        check("t6_strobe", out_new_sample, 0);
        expect_out(8'hD5, 0);
        write(8'hD5);
        check("t6_not_yet", out_new_sample, 0);
        step();
        check("t6_strobe_out", out_new_sample, 1);
        check("t6_data_out", out_sample, 8'hD5);
        step(3);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
